// File: rtl/gated_sr_bank.sv
// Bank of WIDTH gated SR flip-flops with configurable S=R=1 resolution and sticky conflict flags.
// Define GATED_SR_CONFLICT_CNT_EN to build in the saturating conflict-cycle counter on err_cnt.
module gated_sr_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_chg,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_chg_q, q_chg_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] conflict;

  assign conflict = en ? (s & r) : '0;

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({s[i], r[i]})
          2'b10: q_d[i] = 1'b1;
          2'b01: q_d[i] = 1'b0;
          2'b11: begin
            // Out-of-range MODE values fall back to hold.
            case (MODE)
              32'd1:   q_d[i] = 1'b1;
              32'd2:   q_d[i] = 1'b0;
              32'd3:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  assign q_chg_d = q_d ^ q_q;
  // A new conflict in the clearing cycle re-sets the flag.
  assign err_d   = (err_clr ? '0 : err_q) | conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      q_chg_q <= '0;
      err_q   <= '0;
    end else begin
      q_q     <= q_d;
      q_chg_q <= q_chg_d;
      err_q   <= err_d;
    end
  end

  assign q     = q_q;
  assign qbar  = ~q_q;
  assign q_chg = q_chg_q;
  assign err   = err_q;

`ifdef GATED_SR_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_conflict;

  assign any_conflict = |conflict;

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = any_conflict ? CntOne : '0;
    end else if (any_conflict && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
